// File: rtl/fifo_pkg.sv
// Shared helpers for the async FIFO pointer logic (read and write sides).
// Gray conversions run on a wide word; callers zero-extend and truncate to their width.
package fifo_pkg;

   localparam int ADDRSIZE_DEF = 4;
   localparam int PTR_MAX      = 32;

   typedef logic [PTR_MAX-1:0] ptr_word_t;

   function automatic ptr_word_t bin2gray(input ptr_word_t b);
      return b ^ (b >> 1);
   endfunction

   // Zero upper bits do not disturb the prefix XOR, so any width up to PTR_MAX works.
   function automatic ptr_word_t gray2bin(input ptr_word_t g);
      ptr_word_t b;
      b = '0;
      for (int i = 0; i < PTR_MAX; i++) b[i] = ^(g >> i);
      return b;
   endfunction

endpackage

// File: rtl/ptr_sync.sv
// Multi-bit flop chain for carrying a Gray pointer across clock domains.
// Output is the last stage; synchronous active-high reset clears every stage.
module ptr_sync #(
   parameter int WIDTH  = 5,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [STAGES-1:0][WIDTH-1:0] stage_d, stage_q;

   always_comb begin
      stage_d    = stage_q;
      stage_d[0] = i_d;
      for (int i = 1; i < STAGES; i++) stage_d[i] = stage_q[i-1];
   end

   always_ff @(posedge clk) begin
      if (rst) stage_q <= '0;
      else     stage_q <= stage_d;
   end

   assign o_q = stage_q[STAGES-1];

endmodule

// File: rtl/fifo_empty.sv
// Read-side pointer and flag controller of the async FIFO: read address, Gray read
// pointer for the write domain, and empty / almost-empty / level / underflow status.
module fifo_empty
   import fifo_pkg::*;
#(
   parameter int ADDRSIZE      = ADDRSIZE_DEF,
   parameter int SYNC_STAGES   = 2,
   parameter int AEMPTY_THRESH = 2
) (
   input  logic                i_rd_clk,
   input  logic                i_rd_rst,
   input  logic                i_rd_en,
   input  logic [ADDRSIZE:0]   i_wr_ptr,
   output logic                o_empty,
   output logic                o_almost_empty,
   output logic [ADDRSIZE-1:0] o_rd_addr,
   output logic [ADDRSIZE:0]   o_rd_ptr,
   output logic [ADDRSIZE:0]   o_rd_level,
   output logic                o_underflow
);

   localparam int PW = ADDRSIZE + 1;

   logic [PW-1:0] wr_ptr_sync;
   logic [PW-1:0] rd_bin_d, rd_bin_q;
   logic [PW-1:0] rd_ptr_d, rd_ptr_q;
   logic [PW-1:0] level_d, level_q;
   logic          empty_d, empty_q;
   logic          aempty_d, aempty_q;
   logic          underflow_d, underflow_q;
   logic          rd_inc;

   ptr_sync #(.WIDTH(PW), .STAGES(SYNC_STAGES)) u_wr_sync (
      .clk (i_rd_clk),
      .rst (i_rd_rst),
      .i_d (i_wr_ptr),
      .o_q (wr_ptr_sync)
   );

   // Flags are computed from the post-read pointer so the read that takes the
   // last word raises empty on the same edge.
   always_comb begin
      rd_inc      = i_rd_en & ~empty_q;
      rd_bin_d    = rd_bin_q + PW'(rd_inc);
      rd_ptr_d    = PW'(bin2gray(ptr_word_t'(rd_bin_d)));
      empty_d     = (rd_ptr_d == wr_ptr_sync);
      level_d     = PW'(gray2bin(ptr_word_t'(wr_ptr_sync))) - rd_bin_d;
      aempty_d    = (level_d <= PW'(AEMPTY_THRESH));
      underflow_d = underflow_q | (i_rd_en & empty_q);
   end

   always_ff @(posedge i_rd_clk) begin
      if (i_rd_rst) begin
         rd_bin_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
         empty_q     <= 1'b1;
         aempty_q    <= 1'b1;
         underflow_q <= 1'b0;
      end else begin
         rd_bin_q    <= rd_bin_d;
         rd_ptr_q    <= rd_ptr_d;
         level_q     <= level_d;
         empty_q     <= empty_d;
         aempty_q    <= aempty_d;
         underflow_q <= underflow_d;
      end
   end

   assign o_empty        = empty_q;
   assign o_almost_empty = aempty_q;
   assign o_rd_addr      = rd_bin_q[ADDRSIZE-1:0];
   assign o_rd_ptr       = rd_ptr_q;
   assign o_rd_level     = level_q;
   assign o_underflow    = underflow_q;

endmodule

// File: tb/tb_fifo_empty.sv
// Directed and random stimulus for fifo_empty against a count-based reference model.
module tb_fifo_empty;

   localparam int AW = 4;
   localparam int PW = AW + 1;
   localparam int SS = 2;
   localparam int TH = 2;
   localparam int NWORD = 1 << PW;

   logic          clk = 1'b0;
   logic          rst, en;
   logic [PW-1:0] wr_ptr;
   logic          o_empty, o_almost_empty, o_underflow;
   logic [AW-1:0] o_rd_addr;
   logic [PW-1:0] o_rd_ptr, o_rd_level;

   always #5 clk = ~clk;

   fifo_empty #(.ADDRSIZE(AW), .SYNC_STAGES(SS), .AEMPTY_THRESH(TH)) dut (
      .i_rd_clk       (clk),
      .i_rd_rst       (rst),
      .i_rd_en        (en),
      .i_wr_ptr       (wr_ptr),
      .o_empty        (o_empty),
      .o_almost_empty (o_almost_empty),
      .o_rd_addr      (o_rd_addr),
      .o_rd_ptr       (o_rd_ptr),
      .o_rd_level     (o_rd_level),
      .o_underflow    (o_underflow)
   );

   int n_assert = 0;
   int n_fail   = 0;

   // Model: words written (w) and read (m_r) as counts mod 2^(AW+1); the write
   // count seen by the read side is the value sampled SS edges earlier.
   int            w = 0;
   int            m_r, m_lvl;
   bit            m_e, m_ae, m_uf;
   int            hist[SS];
   logic [PW-1:0] prev_ptr = '0;

   function automatic logic [PW-1:0] gray(input int v);
      logic [PW-1:0] b;
      b = PW'(v);
      return b ^ (b >> 1);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      int  wsync;
      bit  inc;
      @(posedge clk);
      if (rst) begin
         m_r = 0; m_lvl = 0; m_e = 1; m_ae = 1; m_uf = 0;
         for (int i = 0; i < SS; i++) hist[i] = 0;
      end else begin
         wsync = hist[SS-1];
         inc   = en && !m_e;
         if (en && m_e) m_uf = 1;
         m_r   = (m_r + int'(inc)) % NWORD;
         m_lvl = (wsync - m_r + NWORD) % NWORD;
         m_e   = (m_lvl == 0);
         m_ae  = (m_lvl <= TH);
         for (int i = SS-1; i > 0; i--) hist[i] = hist[i-1];
         hist[0] = w;
      end
      #1;
      chk("empty",    32'(o_empty),        32'(m_e));
      chk("aempty",   32'(o_almost_empty), 32'(m_ae));
      chk("underflow",32'(o_underflow),    32'(m_uf));
      chk("rd_ptr",   32'(o_rd_ptr),       32'(gray(m_r)));
      chk("rd_addr",  32'(o_rd_addr),      32'(m_r % (1 << AW)));
      chk("rd_level", 32'(o_rd_level),     32'(m_lvl));
      chk("gray_step",32'($countones(prev_ptr ^ o_rd_ptr) <= 1), 32'd1);
      prev_ptr = o_rd_ptr;
   endtask

   task automatic wstep();
      w      = (w + 1) % NWORD;
      wr_ptr = gray(w);
      tick();
   endtask

   initial begin
      rst = 1'b1; en = 1'b1; wr_ptr = '0; w = 0;
      tick(); tick();
      chk("rst_empty", 32'(o_empty), 32'd1);
      chk("rst_aempty", 32'(o_almost_empty), 32'd1);
      chk("rst_ptr", 32'(o_rd_ptr), 32'd0);
      chk("rst_addr", 32'(o_rd_addr), 32'd0);
      chk("rst_level", 32'(o_rd_level), 32'd0);
      chk("rst_uf", 32'(o_underflow), 32'd0);

      // Fill: write pointer jumps to 3 (gray 00010), visible after three edges
      rst = 1'b0; en = 1'b0; w = 3; wr_ptr = 5'b00010;
      tick(); tick();
      chk("fill_still_empty", 32'(o_empty), 32'd1);
      tick();
      chk("fill_empty", 32'(o_empty), 32'd0);
      chk("fill_level", 32'(o_rd_level), 32'd3);
      chk("fill_aempty", 32'(o_almost_empty), 32'd0);

      // Drain three words
      en = 1'b1;
      chk("drain_addr0", 32'(o_rd_addr), 32'd0);
      tick();
      chk("drain_ptr1", 32'(o_rd_ptr), 32'b00001);
      chk("drain_addr1", 32'(o_rd_addr), 32'd1);
      tick();
      chk("drain_ptr2", 32'(o_rd_ptr), 32'b00011);
      chk("drain_addr2", 32'(o_rd_addr), 32'd2);
      tick();
      chk("drain_ptr3", 32'(o_rd_ptr), 32'b00010);
      chk("drain_empty", 32'(o_empty), 32'd1);
      chk("drain_level", 32'(o_rd_level), 32'd0);
      chk("drain_aempty", 32'(o_almost_empty), 32'd1);
      chk("drain_uf", 32'(o_underflow), 32'd0);

      // Underflow: read while empty
      tick();
      chk("uf_ptr_hold", 32'(o_rd_ptr), 32'b00010);
      chk("uf_set", 32'(o_underflow), 32'd1);
      en = 1'b0;
      tick(); tick();
      chk("uf_sticky", 32'(o_underflow), 32'd1);

      // Wrap: fill to full, drain, refill across write wrap, drain across read wrap
      rst = 1'b1; tick(); rst = 1'b0;
      chk("uf_cleared", 32'(o_underflow), 32'd0);
      while (w != 16) wstep();
      repeat (SS + 1) tick();
      chk("full_level", 32'(o_rd_level), 32'd16);
      chk("full_empty", 32'(o_empty), 32'd0);
      en = 1'b1;
      repeat (16) tick();
      en = 1'b0;
      repeat (16) wstep();
      repeat (SS + 1) tick();
      chk("wrap_w0", 32'(w), 32'd0);
      chk("wrap_level16", 32'(o_rd_level), 32'd16);
      chk("wrap_empty", 32'(o_empty), 32'd0);
      chk("wrap_ptr16", 32'(o_rd_ptr), 32'b11000);
      chk("wrap_addr16", 32'(o_rd_addr), 32'd0);
      en = 1'b1;
      repeat (15) tick();
      chk("wrap_addr15", 32'(o_rd_addr), 32'd15);
      chk("wrap_ptr31", 32'(o_rd_ptr), 32'b10000);
      tick();
      en = 1'b0;
      chk("wrap_ptr0", 32'(o_rd_ptr), 32'd0);
      chk("wrap_addr0", 32'(o_rd_addr), 32'd0);
      chk("wrap_drained", 32'(o_empty), 32'd1);

      // Mid-operation reset with five words buffered
      repeat (5) wstep();
      repeat (SS + 1) tick();
      chk("mid_level5", 32'(o_rd_level), 32'd5);
      rst = 1'b1; en = 1'b1;
      tick();
      chk("mid_rst_empty", 32'(o_empty), 32'd1);
      chk("mid_rst_level", 32'(o_rd_level), 32'd0);
      chk("mid_rst_ptr", 32'(o_rd_ptr), 32'd0);
      rst = 1'b0; en = 1'b0;
      tick(); tick();
      chk("mid_rel_empty", 32'(o_empty), 32'd1);
      tick();
      chk("mid_rel_nempty", 32'(o_empty), 32'd0);
      chk("mid_rel_level", 32'(o_rd_level), 32'd5);

      // Random traffic; writes never lap the read count by more than 2^AW
      for (int c = 0; c < 600; c++) begin
         en = ($urandom_range(0, 99) < 55);
         if ($urandom_range(0, 99) < 50 && ((w - m_r + NWORD) % NWORD) < 16)
            wstep();
         else
            tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
